dmem_banked_ctrl: RTL

//  Parametrised, handshaked data memory for the single-cycle CPU datapath.
//  - Byte, half, word and (DATA_W=64 only) dword loads/stores, with sign or zero extension on loads.
//  - Configurable wait states and valid/ready request/response channels.
//  - Sits between the execute stage and on-chip RAM.

---
 rtl/dmem_banked_ctrl_pkg.sv | 55 +++++
 rtl/dmem_banked_ctrl_if.sv | 30 +++
 rtl/dmem_banked_ctrl_load_align.sv | 46 ++++
 rtl/dmem_banked_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_banked_ctrl_pkg.sv
// Shared types and lane helpers for the banked data memory controller.
// Lane helpers work on an 8-lane (64-bit) layout; 32-bit builds use the low half.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_NB = 8;

  // Byte enables for an access of the given size, aligned down to that size.
  function automatic logic [MAX_NB-1:0] lane_mask(input size_e size, input logic [2:0] off);
    logic [MAX_NB-1:0] m;
    unique case (size)
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << {off[2:1], 1'b0};
      SZ_W:    m = 8'h0F << {off[2], 2'b00};
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
    logic mis;
    unique case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Byte offset rounded down to the access size.
  function automatic logic [2:0] align_off(input size_e size, input logic [2:0] off);
    logic [2:0] a;
    unique case (size)
      SZ_B:    a = off;
      SZ_H:    a = {off[2:1], 1'b0};
      SZ_W:    a = {off[2], 2'b00};
      default: a = 3'b000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/dmem_banked_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the data memory (slave).
interface dmem_banked_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_W+OFF_W-1:0] req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_banked_ctrl_load_align.sv
// Combinational load path: pull the addressed lanes down to bit 0 and sign/zero extend.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 2
) (
  input  logic [DATA_W-1:0] i_word,
  input  size_e             i_size,
  input  logic [OFF_W-1:0]  i_off,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  assign w_shift = i_word >> {i_off, 3'b000};

  // Keep mask selects the loaded lanes; everything above is filled with the sign bit or zero.
  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    unique case (i_size)
      SZ_B: begin
        w_keep = DATA_W'(8'hFF);
        w_sign = i_signed & w_shift[7];
      end
      SZ_H: begin
        w_keep = DATA_W'(16'hFFFF);
        w_sign = i_signed & w_shift[15];
      end
      SZ_W: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_sign = i_signed & w_shift[31];
      end
      default: begin
        w_keep = '1;
        w_sign = 1'b0;
      end
    endcase
    o_data = (w_shift & w_keep) | (w_sign ? ~w_keep : '0);
  end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Handshaked, byte-laned data memory with configurable wait states.
// Build option DMEM_ALIGN_ERR_EN: when defined, misaligned or illegal accesses fault
// (store suppressed, rsp_err=1, rsp_rdata=0); otherwise the address is aligned down,
// size 11 on a 32-bit build acts as a word, and rsp_err stays 0.
// Even with WAIT_CYC=0 one cycle is spent in ST_WAIT to perform the RAM access, so the
// response always appears 1+WAIT_CYC edges after accept.
module dmem_banked_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned WAIT_CYC = 0
) (
  input logic                clk,
  input logic                rst_n,
  dmem_banked_ctrl_if.slave  io_bus
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned OFF_W    = $clog2(NB);
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYC);

  // Control and capture state
  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  size_e               r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_idx;
  logic [OFF_W-1:0]    r_off;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  size_e               w_req_size;
  size_e               w_eff_size;
  logic [2:0]          w_req_off3;
  logic                w_illegal;
  logic                w_req_err;
  logic [OFF_W-1:0]    w_aoff;
  logic                w_req_ready;
  logic                w_accept;
  logic                w_access;
  logic [NB-1:0]       w_mask;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_load;

  assign w_req_size = size_e'(io_bus.req_size);
  assign w_req_off3 = 3'(io_bus.req_addr[OFF_W-1:0]);
  assign w_illegal  = (DATA_W == 32) && (w_req_size == SZ_D);

  // Decide the effective size and fault status of the incoming request.
  always_comb begin
`ifdef DMEM_ALIGN_ERR_EN
    w_eff_size = w_req_size;
    w_req_err  = w_illegal | is_misaligned(w_req_size, w_req_off3);
`else
    w_eff_size = w_illegal ? SZ_W : w_req_size;
    w_req_err  = 1'b0;
`endif
    w_aoff = OFF_W'(align_off(w_eff_size, w_req_off3));
  end

  assign w_req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && io_bus.rsp_ready);
  assign w_accept    = io_bus.req_valid && w_req_ready;
  assign w_access    = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  assign w_mask     = NB'(lane_mask(r_size, 3'(r_off)));
  assign w_wdata_sh = r_wdata << {r_off, 3'b000};
  assign w_rd_word  = r_mem[r_idx];

  dmem_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .i_word   (w_rd_word),
    .i_size   (r_size),
    .i_off    (r_off),
    .i_signed (r_signed),
    .o_data   (w_load)
  );

  // RAM store: commit the selected lanes on the access edge; faulted stores never write.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !r_err) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mask[i]) begin
          r_mem[r_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // FSM, wait counter, request capture and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_signed    <= 1'b0;
      r_idx       <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= io_bus.req_we;
        r_size   <= w_eff_size;
        r_signed <= io_bus.req_signed;
        r_idx    <= io_bus.req_addr[ADDR_W+OFF_W-1:OFF_W];
        r_off    <= w_aoff;
        r_wdata  <= io_bus.req_wdata;
        r_err    <= w_req_err;
        r_cnt    <= CNT_INIT;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_we || r_err) ? '0 : w_load;
            r_rsp_err   <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= w_accept ? ST_WAIT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;

endmodule
